button_conditioner: RTL and testbench
=====================================

# button_conditioner

Front-end conditioning stage for the stopwatch/timer front panel. It sits directly upstream of the timer core and turns the three raw, bouncing push-buttons (split/reset, mode, start/stop) into clean, registered, single-cycle event pulses. The core consumes these pulses instead of raw edges. Each button gets press, release, long-press and auto-repeat events, so the core's edit-time modes can step digits while a button is held.

## Interface
- DEBOUNCE_CYCLES, 4: consecutive cycles a synchronized level must differ from the accepted level before it is accepted; legal range ≥1.
- LONG_PRESS_CYCLES, 200: cycles after the accepted press until the long-press event (2 s at 100 Hz); legal range ≥1.
- REPEAT_CYCLES, 20: auto-repeat period after a long press; 0 disables repeat.
- clockSignal  in  1  single system clock (100 Hz tick domain of the timer core).
- resetN  in  1  reset; synchronous and active-low.
- buttonRaw  in  3  asynchronous raw buttons, active-high. Bit 0 = splitOrReset, bit 1 = modeInput, bit 2 = startOrStop.
- buttonLevel  out  3  debounced accepted level per button.
- pressPulse  out  3  one-cycle pulse when a button's accepted level rises.
- releasePulse  out  3  one-cycle pulse when a button's accepted level falls.
- longPressPulse  out  3  one-cycle pulse LONG_PRESS_CYCLES after the press, if the button is still held.
- repeatPulse  out  3  one-cycle pulse every REPEAT_CYCLES after the long press while the button is held.

## Operation
- The three channels are fully independent and identical. There is no priority or interlock between buttons; simultaneous activity on several bits produces simultaneous pulses.
- Synchronizer: 2-flop chain per bit; flop reset value 0.
- Debounce: accepted level `stable` plus counter `dbCnt`.
  - When the synchronized input equals `stable`, `dbCnt` clears to 0.
  - Otherwise `dbCnt` increments.
  - When a mismatch is seen with `dbCnt == DEBOUNCE_CYCLES-1`, `stable` toggles and `dbCnt` clears.
  - Any bounce back to the accepted level restarts the count.
- Each channel has a hold-state FSM with three states: IDLE, HELD, LONG.
  - IDLE → HELD on `stable` rise; `pressPulse` asserts in that cycle and `holdCnt` clears.
  - HELD: `holdCnt` increments each cycle. When it reaches LONG_PRESS_CYCLES, `longPressPulse` asserts, the FSM moves to LONG and `repCnt` clears.
  - LONG: `repCnt` increments. When it reaches REPEAT_CYCLES (and REPEAT_CYCLES≠0), `repeatPulse` asserts and `repCnt` clears.
  - Any state → IDLE on `stable` fall; `releasePulse` asserts and all counters clear.
  - A release in HELD never produces `longPressPulse`.
- Counters are sized with $clog2(max+1). `holdCnt` saturates and never wraps. `repCnt` wraps only by explicit clear.

## Timing
- Every output is registered. All outputs reset to 0; `stable` = 0, FSM = IDLE, all counters = 0.
- Latency from a clean raw rise/fall (set up before edge 0) to `pressPulse`/`releasePulse` high: edge 2+DEBOUNCE_CYCLES. `buttonLevel` changes on the same edge.
- `longPressPulse` at press edge P + LONG_PRESS_CYCLES.
- `repeatPulse` at P + LONG_PRESS_CYCLES + k·REPEAT_CYCLES, for k≥1.
- Every pulse is exactly 1 cycle wide.
- Release coinciding with a long or repeat boundary: the release wins and no long/repeat pulse is emitted that cycle.
- Reset mid-operation: while `resetN` is low, all state clears on every edge. A button held through reset is re-debounced from 0, so a fresh `pressPulse` follows 2+DEBOUNCE_CYCLES edges after reset release.
- Inputs shorter than DEBOUNCE_CYCLES synchronized cycles produce no event.

## Structure
- Shared package `panel_pkg`:
  - button index constants: BTN_SPLIT=0, BTN_MODE=1, BTN_START=2
  - NUM_BUTTONS=3
  - hold-FSM state enum {IDLE, HELD, LONG}
- Sub-module `button_channel`: synchronizer, debounce and hold FSM for one bit, carrying the same parameters. `button_conditioner` instantiates it NUM_BUTTONS times via generate.

## Test plan
All scenarios use DEBOUNCE_CYCLES=4, LONG_PRESS_CYCLES=10, REPEAT_CYCLES=3.
- Clean press on bit 1 set before edge 0, held 8 cycles, then released → `pressPulse[1]` at edge 6 only; `buttonLevel[1]` high edges 6–13; `releasePulse[1]` at edge 14; no long pulse.
- Bit 0 toggles every 2 cycles for 12 cycles, then settles high → no event during the bounce; exactly one `pressPulse[0]` 6 edges after the last toggle.
- Bit 2 held 30 cycles, press at edge P → `longPressPulse[2]` at P+10; `repeatPulse[2]` at P+13, P+16, P+19, …; `releasePulse[2]` on release; no repeat after release.
- Glitches of 3 cycles high on all bits → all outputs stay 0.
- Bits 0 and 2 pressed in the same cycle → identical, simultaneous `pressPulse` on both bits; bit 1 stays quiet.
- `resetN` low for 2 cycles at P+5 during a hold on bit 1 → all outputs 0 during reset; new `pressPulse[1]` 6 edges after `resetN` returns high; long pulse 10 cycles after that.

Source files
------------

// File: rtl/panel_pkg.sv
// panel_pkg: shared constants and types for the front-panel button logic
package panel_pkg;
  localparam int BTN_SPLIT = 0;
  localparam int BTN_MODE = 1;
  localparam int BTN_START = 2;
  localparam int NUM_BUTTONS = 3;
  typedef enum logic [1:0] {IDLE, HELD, LONG} hold_state_t;
endpackage

// File: rtl/button_channel.sv
// button_channel: synchronize, debounce and classify one push-button into event pulses
module button_channel
  import panel_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int LONG_PRESS_CYCLES = 200,
  parameter int REPEAT_CYCLES = 20
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic level,
  output logic press,
  output logic rel,
  output logic long_press,
  output logic rep
);
  localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int HOLD_W = $clog2(LONG_PRESS_CYCLES + 1);
  localparam int REP_W = REPEAT_CYCLES > 0 ? $clog2(REPEAT_CYCLES + 1) : 1;
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_PRESS_CYCLES - 1);
  localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(LONG_PRESS_CYCLES);
  localparam logic [REP_W-1:0] REP_LAST = REP_W'(REPEAT_CYCLES > 0 ? REPEAT_CYCLES - 1 : 0);

  logic [1:0] sync;
  logic stable;
  logic [DB_W-1:0] db_cnt;
  hold_state_t state, state_n;
  logic [HOLD_W-1:0] hold_cnt, hold_n;
  logic [REP_W-1:0] rep_cnt, rep_n;
  logic press_n, rel_n, long_n, rep_p_n;

  // two-flop synchronizer for the asynchronous raw input
  always_ff @(posedge clk)
    sync <= !rst_n ? 2'b00 : {sync[0], raw};

  // accept a new level only after DEBOUNCE_CYCLES consecutive mismatching samples
  always_ff @(posedge clk)
    if (!rst_n) begin
      stable <= 1'b0;
      db_cnt <= '0;
    end else if (sync[1] == stable) begin
      db_cnt <= '0;
    end else if (db_cnt == DB_LAST) begin
      stable <= !stable;
      db_cnt <= '0;
    end else begin
      db_cnt <= db_cnt + 1'b1;
    end

  // hold FSM: press/release on accepted edges, long press after the hold time, then repeats
  always_comb begin
    state_n = state;
    hold_n = hold_cnt;
    rep_n = rep_cnt;
    press_n = 1'b0;
    rel_n = 1'b0;
    long_n = 1'b0;
    rep_p_n = 1'b0;
    if (state == IDLE) begin
      state_n = stable ? HELD : IDLE;
      press_n = stable;
      hold_n = '0;
    end else if (!stable) begin
      state_n = IDLE;
      rel_n = 1'b1;
      hold_n = '0;
      rep_n = '0;
    end else if (state == HELD) begin
      state_n = hold_cnt == HOLD_LAST ? LONG : HELD;
      long_n = hold_cnt == HOLD_LAST;
      rep_n = '0;
      hold_n = hold_cnt == HOLD_MAX ? hold_cnt : hold_cnt + 1'b1;
    end else if (REPEAT_CYCLES != 0) begin
      rep_p_n = rep_cnt == REP_LAST;
      rep_n = rep_cnt == REP_LAST ? '0 : rep_cnt + 1'b1;
    end
  end

  // state, counters and every output update together so all pulses are registered
  always_ff @(posedge clk)
    if (!rst_n) begin
      state <= IDLE;
      hold_cnt <= '0;
      rep_cnt <= '0;
      level <= 1'b0;
      press <= 1'b0;
      rel <= 1'b0;
      long_press <= 1'b0;
      rep <= 1'b0;
    end else begin
      state <= state_n;
      hold_cnt <= hold_n;
      rep_cnt <= rep_n;
      level <= stable;
      press <= press_n;
      rel <= rel_n;
      long_press <= long_n;
      rep <= rep_p_n;
    end
endmodule

// File: rtl/button_conditioner.sv
// button_conditioner: independent conditioning channels for the three front-panel buttons
module button_conditioner
  import panel_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int LONG_PRESS_CYCLES = 200,
  parameter int REPEAT_CYCLES = 20
) (
  input  logic                   clockSignal,
  input  logic                   resetN,
  input  logic [NUM_BUTTONS-1:0] buttonRaw,
  output logic [NUM_BUTTONS-1:0] buttonLevel,
  output logic [NUM_BUTTONS-1:0] pressPulse,
  output logic [NUM_BUTTONS-1:0] releasePulse,
  output logic [NUM_BUTTONS-1:0] longPressPulse,
  output logic [NUM_BUTTONS-1:0] repeatPulse
);
  generate
    for (genvar i = 0; i < NUM_BUTTONS; i++) begin : g_ch
      button_channel #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .LONG_PRESS_CYCLES(LONG_PRESS_CYCLES),
        .REPEAT_CYCLES(REPEAT_CYCLES)
      ) u_ch (
        .clk(clockSignal),
        .rst_n(resetN),
        .raw(buttonRaw[i]),
        .level(buttonLevel[i]),
        .press(pressPulse[i]),
        .rel(releasePulse[i]),
        .long_press(longPressPulse[i]),
        .rep(repeatPulse[i])
      );
    end
  endgenerate
endmodule

// File: tb/tb_button_conditioner.sv
// tb_button_conditioner: directed scenarios checked every cycle against a timing-rule reference model
module tb_button_conditioner;
  localparam int D = 4;
  localparam int L = 10;
  localparam int R = 3;
  localparam int N = 1024;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [2:0] raw = 3'b000;
  logic [2:0] lvl, prs, rls, lng, rpt;

  button_conditioner #(
    .DEBOUNCE_CYCLES(D),
    .LONG_PRESS_CYCLES(L),
    .REPEAT_CYCLES(R)
  ) dut (
    .clockSignal(clk),
    .resetN(rst_n),
    .buttonRaw(raw),
    .buttonLevel(lvl),
    .pressPulse(prs),
    .releasePulse(rls),
    .longPressPulse(lng),
    .repeatPulse(rpt)
  );

  always #5 clk = ~clk;

  int n = -1;
  int pass_cnt = 0;
  int chk_cnt = 0;
  logic [2:0] m_s1, m_s2, m_prev, m_acc, m_lvl, m_prs, m_rls, m_lng, m_rpt;
  int since[3];
  int press_at[3];
  logic [2:0] h_lvl[N], h_prs[N], h_rls[N], h_lng[N], h_rpt[N];

  // reference: raw delayed two edges; level accepted once D identical differing samples are seen;
  // events derived from the accepted level and the elapsed time since the press edge
  task automatic model_step();
    n++;
    if (!rst_n) begin
      {m_s1, m_s2, m_prev, m_acc, m_lvl, m_prs, m_rls, m_lng, m_rpt} = '0;
      for (int i = 0; i < 3; i++) since[i] = n;
    end else begin
      for (int i = 0; i < 3; i++) begin
        int held;
        logic acc_next;
        if (m_s2[i] != m_prev[i]) since[i] = n;
        m_prev[i] = m_s2[i];
        acc_next = (m_s2[i] != m_acc[i] && n - since[i] + 1 >= D) ? m_s2[i] : m_acc[i];
        m_prs[i] = m_acc[i] && !m_lvl[i];
        m_rls[i] = !m_acc[i] && m_lvl[i];
        if (m_prs[i]) press_at[i] = n;
        held = n - press_at[i];
        m_lng[i] = m_acc[i] && m_lvl[i] && held == L;
        m_rpt[i] = m_acc[i] && m_lvl[i] && R != 0 && held > L && (held - L) % R == 0;
        m_lvl[i] = m_acc[i];
        m_acc[i] = acc_next;
        m_s2[i] = m_s1[i];
        m_s1[i] = raw[i];
      end
    end
  endtask

  task automatic chk(string name, logic [2:0] act, logic [2:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s edge %0d: got %b expected %b", name, n, act, exp);
  endtask

  task automatic chki(string name, int act, int exp);
    chk_cnt++;
    if (act == exp) pass_cnt++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    @(negedge clk);
    if (n < N) begin
      h_lvl[n] = lvl;
      h_prs[n] = prs;
      h_rls[n] = rls;
      h_lng[n] = lng;
      h_rpt[n] = rpt;
    end
    chk("buttonLevel", lvl, m_lvl);
    chk("pressPulse", prs, m_prs);
    chk("releasePulse", rls, m_rls);
    chk("longPressPulse", lng, m_lng);
    chk("repeatPulse", rpt, m_rpt);
  endtask

  task automatic run(int k);
    repeat (k) cycle();
  endtask

  function automatic int cnt(int kind, int b, int from, int to);
    int c = 0;
    for (int e = from; e <= to; e++) begin
      logic [2:0] v;
      v = kind == 0 ? h_prs[e] : kind == 1 ? h_rls[e] : kind == 2 ? h_lng[e] :
          kind == 3 ? h_rpt[e] : h_lvl[e];
      c += int'(v[b]);
    end
    return c;
  endfunction

  initial begin
    int b, p, q;
    run(3);
    chk("reset_outputs", lvl | prs | rls | lng | rpt, 3'b000);
    rst_n = 1'b1;
    run(3);

    // clean press on bit 1, held 8 cycles
    b = n + 1;
    raw = 3'b010;
    run(8);
    raw = 3'b000;
    run(16);
    chki("s1_press_edge", int'(h_prs[b+6][1]), 1);
    chki("s1_press_count", cnt(0, 1, b, b + 23), 1);
    chki("s1_level_before", int'(h_lvl[b+5][1]), 0);
    chki("s1_level_span", cnt(4, 1, b, b + 23), 8);
    chki("s1_level_last", int'(h_lvl[b+13][1]), 1);
    chki("s1_release_edge", int'(h_rls[b+14][1]), 1);
    chki("s1_no_long", cnt(2, 1, b, b + 23), 0);

    // bounce on bit 0, then settle high
    b = n + 1;
    for (int k = 0; k < 12; k++) begin
      raw[0] = ((k / 2) % 2) == 0;
      run(1);
    end
    raw[0] = 1'b1;
    run(20);
    chki("s2_quiet_bounce", cnt(0, 0, b, b + 17), 0);
    chki("s2_press_edge", int'(h_prs[b+18][0]), 1);
    chki("s2_press_count", cnt(0, 0, b, b + 31), 1);
    raw = 3'b000;
    run(12);

    // long hold on bit 2 with auto-repeat
    b = n + 1;
    p = b + 6;
    raw = 3'b100;
    run(30);
    raw = 3'b000;
    run(12);
    chki("s3_press_edge", int'(h_prs[p][2]), 1);
    chki("s3_long_edge", int'(h_lng[p+10][2]), 1);
    chki("s3_long_count", cnt(2, 2, b, b + 41), 1);
    chki("s3_repeat_first", int'(h_rpt[p+13][2]), 1);
    chki("s3_repeat_second", int'(h_rpt[p+16][2]), 1);
    chki("s3_repeat_count", cnt(3, 2, b, b + 41), 6);
    chki("s3_release_edge", int'(h_rls[p+30][2]), 1);
    chki("s3_no_repeat_after", cnt(3, 2, p + 30, b + 41), 0);

    // 3-cycle glitch on every bit
    b = n + 1;
    raw = 3'b111;
    run(3);
    raw = 3'b000;
    run(12);
    q = 0;
    for (int k = 0; k < 5; k++)
      for (int i = 0; i < 3; i++) q += cnt(k, i, b, b + 14);
    chki("s4_glitch_quiet", q, 0);

    // simultaneous press on bits 0 and 2
    b = n + 1;
    raw = 3'b101;
    run(10);
    chk("s5_simultaneous", h_prs[b+6], 3'b101);
    chki("s5_bit1_quiet", cnt(0, 1, b, b + 9), 0);
    raw = 3'b000;
    run(10);

    // reset pulse in the middle of a hold on bit 1
    b = n + 1;
    p = b + 6;
    raw = 3'b010;
    run(11);
    rst_n = 1'b0;
    run(2);
    rst_n = 1'b1;
    run(30);
    chk("s6_reset_edge0", h_lvl[p+5] | h_prs[p+5] | h_rls[p+5] | h_lng[p+5] | h_rpt[p+5], 3'b000);
    chk("s6_reset_edge1", h_lvl[p+6] | h_prs[p+6] | h_rls[p+6] | h_lng[p+6] | h_rpt[p+6], 3'b000);
    chki("s6_no_early_press", cnt(0, 1, p + 7, p + 12), 0);
    chki("s6_repress_edge", int'(h_prs[p+13][1]), 1);
    chki("s6_long_edge", int'(h_lng[p+23][1]), 1);
    raw = 3'b000;
    run(10);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end
endmodule
